// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned DATA_W = 8;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte hand-off from the receiver to its consumer, plus status strobes.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] oDATA;
    logic              oVALID;
    logic              iREADY;
    logic              oFRAME_ERR;
    logic              oOVERRUN;
    logic              oBUSY;

    modport master (
        output oDATA, oVALID, oFRAME_ERR, oOVERRUN, oBUSY,
        input  iREADY
    );

    modport slave (
        input  oDATA, oVALID, oFRAME_ERR, oOVERRUN, oBUSY,
        output iREADY
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            cnt <= '0;
        else if (clear || cnt == CW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = !clear && (cnt == CW'(DIV - 1));
endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-entry
// valid/ready holding register.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iRXD,
    uart_rx_byte_if.master bus
);
    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned IW  = $clog2(DATA_W);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    rx_state_t         state, state_n;
    logic              rx_m, rx_s, rx_d;
    logic              tick;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic              ferr_q, ferr_n;
    logic              ovr_q, ovr_n;
    logic              done;

    // Held clear throughout IDLE so the first tick lands DIV clocks after the start edge.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            state   <= IDLE;
            tcnt    <= '0;
            idx     <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rx_m    <= iRXD;
            rx_s    <= rx_m;
            rx_d    <= rx_s;
            state   <= state_n;
            tcnt    <= tcnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = data_q;
        valid_n = valid_q;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        done    = 1'b0;

        if (valid_q && bus.iREADY)
            valid_n = 1'b0;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (rx_d && !rx_s)
                    state_n = START;
            end
            START: begin
                if (tick) begin
                    if (tcnt == HALF_LAST) begin
                        tcnt_n  = '0;
                        idx_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == FULL_LAST) begin
                        tcnt_n    = '0;
                        sh_n[idx] = rx_s;
                        if (idx == IDX_LAST)
                            state_n = STOP;
                        else
                            idx_n = idx + 1'b1;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tcnt == FULL_LAST) begin
                        tcnt_n = '0;
                        if (rx_s) begin
                            done    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A consumer accepting in the completion cycle frees the slot for the new byte.
        if (done) begin
            if (!valid_q || bus.iREADY) begin
                data_n  = sh;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    assign bus.oDATA      = data_q;
    assign bus.oVALID     = valid_q;
    assign bus.oFRAME_ERR = ferr_q;
    assign bus.oOVERRUN   = ovr_q;
    assign bus.oBUSY      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int unsigned BIT = 432;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned bclk;
        int unsigned hold;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    uart_rx_byte_if bus();

    uart_rx_byte #(
        .CLK_HZ    (50_000_000),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .iRXD  (rxd),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  got_q[$];
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          rise_n = 0;
    int unsigned rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer-side observer: accepted bytes, strobes, and the hold rule.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready)
                check("hold_stable", 32'({bus.oVALID, bus.oDATA}), 32'({1'b1, prev_data}));
            if (bus.oVALID && !prev_valid) begin
                rise_n++;
                rise_cyc = cyc;
            end
            if (bus.oVALID && bus.iREADY) got_q.push_back(bus.oDATA);
            if (bus.oFRAME_ERR) ferr_cnt++;
            if (bus.oOVERRUN) ovr_cnt++;
            if (bus.oFRAME_ERR && bus.oOVERRUN)
                check("ferr_ovr_exclusive", 32'd1, 32'd0);
            prev_valid = bus.oVALID;
            prev_ready = bus.iREADY;
            prev_data  = bus.oDATA;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned bclk);
        rxd = 1'b0;
        step(bclk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            step(bclk);
        end
        rxd = stop;
        step(bclk);
    endtask

    initial begin
        vec_t        vecs[6];
        int          n0, f0, o0;
        int unsigned start, k, guard;
        logic [7:0]  exp_q[$];
        int          exp_ferr;
        logic [7:0]  d;
        logic        stop;

        vecs[0] = '{8'h55, 1'b1, BIT, 0};
        vecs[1] = '{8'hA3, 1'b1, BIT, 0};
        vecs[2] = '{8'hA3, 1'b0, BIT, 2000};
        vecs[3] = '{8'h3C, 1'b1, BIT, 0};
        vecs[4] = '{8'h55, 1'b1, 441, 0};
        vecs[5] = '{8'hA3, 1'b1, 423, 0};

        // Reset with the line held low.
        bus.iREADY = 1'b0;
        rxd        = 1'b0;
        rst_n      = 1'b0;
        step(5);
        check("rst_data", 32'(bus.oDATA), 32'h0);
        check("rst_valid", 32'(bus.oVALID), 32'h0);
        check("rst_ferr", 32'(bus.oFRAME_ERR), 32'h0);
        check("rst_ovr", 32'(bus.oOVERRUN), 32'h0);
        check("rst_busy", 32'(bus.oBUSY), 32'h0);
        rxd = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(10000);
        check("idle_busy", 32'(bus.oBUSY), 32'h0);
        check("idle_no_valid", 32'(rise_n), 32'h0);

        // Short low glitch is rejected silently.
        bus.iREADY = 1'b1;
        rxd = 1'b0;
        step(100);
        rxd = 1'b1;
        step(600);
        check("glitch_busy", 32'(bus.oBUSY), 32'h0);
        check("glitch_valid", 32'(rise_n), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt), 32'h0);

        // Table: back-to-back frames, a framing error with long break, and +/-2% rates.
        for (int v = 0; v < 6; v++) begin
            n0 = got_q.size();
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_byte(vecs[v].data, vecs[v].stop, vecs[v].bclk);
            if (vecs[v].hold > 0) begin
                step(vecs[v].hold);
                rxd = 1'b1;
                step(BIT);
            end
            check($sformatf("vec%0d_count", v), 32'(got_q.size() - n0), vecs[v].stop ? 32'd1 : 32'd0);
            if (vecs[v].stop)
                check($sformatf("vec%0d_data", v), 32'(got_q[$]), 32'(vecs[v].data));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), vecs[v].stop ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - o0), 32'd0);
        end

        // Overrun: second byte dropped, first byte kept.
        step(BIT);
        bus.iREADY = 1'b0;
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_byte(8'h11, 1'b1, BIT);
        send_byte(8'h22, 1'b1, BIT);
        step(20);
        check("ovr_valid", 32'(bus.oVALID), 32'd1);
        check("ovr_data", 32'(bus.oDATA), 32'h11);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("ovr_none_taken", 32'(got_q.size() - n0), 32'd0);
        bus.iREADY = 1'b1;
        step(1);
        check("ovr_accept_drop", 32'(bus.oVALID), 32'd0);
        check("ovr_accept_data", 32'(got_q[$]), 32'h11);

        // Learn the start-to-load cycle offset from a byte arriving into an empty slot.
        bus.iREADY = 1'b0;
        start = cyc;
        send_byte(8'h44, 1'b1, BIT);
        step(5);
        k = rise_cyc - start;
        check("pre_data", 32'(bus.oDATA), 32'h44);

        // Consume exactly in the completion cycle of the next byte.
        o0 = ovr_cnt;
        n0 = got_q.size();
        start = cyc;
        fork
            send_byte(8'h66, 1'b1, BIT);
            begin
                guard = 0;
                while (cyc != start + k - 1 && guard < 20 * BIT) begin
                    step(1);
                    guard++;
                end
                if (guard >= 20 * BIT) check("pulse_timeout", 32'd1, 32'd0);
                bus.iREADY = 1'b1;
                step(1);
                bus.iREADY = 1'b0;
            end
        join
        step(5);
        check("pulse_valid", 32'(bus.oVALID), 32'd1);
        check("pulse_data", 32'(bus.oDATA), 32'h66);
        check("pulse_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("pulse_old_taken", 32'(got_q.size() - n0), 32'd1);
        check("pulse_old_data", 32'(got_q[$]), 32'h44);
        bus.iREADY = 1'b1;
        step(3);
        check("pulse_new_data", 32'(got_q[$]), 32'h66);

        // Reset during bit 4 of 0xF0, then a clean 0x0F.
        n0 = got_q.size();
        f0 = ferr_cnt;
        fork
            send_byte(8'hF0, 1'b1, BIT);
            begin
                step(BIT * 5 + BIT / 2);
                rst_n = 1'b0;
                #1;
                check("midrst_busy", 32'(bus.oBUSY), 32'd0);
                check("midrst_valid", 32'(bus.oVALID), 32'd0);
                step(10);
                rst_n = 1'b1;
            end
        join
        step(BIT);
        send_byte(8'h0F, 1'b1, BIT);
        step(20);
        check("midrst_count", 32'(got_q.size() - n0), 32'd1);
        check("midrst_data", 32'(got_q[$]), 32'h0F);
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Random frames against a byte-stream model.
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_ferr = 0;
        for (int r = 0; r < 4; r++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_byte(d, stop, $urandom_range(423, 441));
            rxd = 1'b1;
            if (stop) begin
                exp_q.push_back(d);
                step($urandom_range(0, BIT));
            end else begin
                exp_ferr++;
                step($urandom_range(BIT, 2 * BIT));
            end
        end
        step(20);
        check("rand_count", 32'(got_q.size() - n0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n0 + i < got_q.size())
                check($sformatf("rand_byte%0d", i), 32'(got_q[n0 + i]), 32'(exp_q[i]));
        end
        check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("rand_ovr", 32'(ovr_cnt - o0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
